// File: rtl/msu_axis_harness.sv
// AXI-stream harness around the msu core: loads one job, unloads the result, reports done or a coded error.
// Optional watchdog is enabled by defining MSU_AXIS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// ARM     | one-cycle MSU kick, input size checked
// SEND    | streaming msu_in beats to the core
// AWAIT   | waiting for start_xfer, output size checked
// RECV    | capturing result beats into msu_out
// DONE    | one-cycle completion pulse
// ERROR   | holds coded error until start or reset
module msu_axis_harness #(
  parameter int AXI_LEN         = 32,
  parameter int IN_XFERS        = 8,
  parameter int OUT_XFERS       = 12,
  parameter int XFER_SIZE_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [IN_XFERS-1:0][AXI_LEN-1:0]     msu_in,
  output logic [OUT_XFERS-1:0][AXI_LEN-1:0]    msu_out,
  output logic                                 valid,
  output logic                                 error,
  output logic [1:0]                           err_code,
  output logic                                 busy,
  output logic [15:0]                          job_count,
  output logic                                 ap_start,
  input  logic                                 start_xfer,
  output logic                                 s_axis_tvalid,
  output logic                                 s_axis_tlast,
  output logic [AXI_LEN-1:0]                   s_axis_tdata,
  input  logic                                 s_axis_tready,
  input  logic [XFER_SIZE_WIDTH-1:0]           s_axis_xfer_size_in_bytes,
  input  logic                                 m_axis_tvalid,
  input  logic [AXI_LEN-1:0]                   m_axis_tdata,
  output logic                                 m_axis_tready,
  input  logic [XFER_SIZE_WIDTH-1:0]           m_axis_xfer_size_in_bytes
);

  localparam int IW = (IN_XFERS > 1) ? $clog2(IN_XFERS) : 1;
  localparam int OW = (OUT_XFERS > 1) ? $clog2(OUT_XFERS) : 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(IN_XFERS - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_XFERS - 1);
  localparam logic [XFER_SIZE_WIDTH-1:0] IN_BYTES  = XFER_SIZE_WIDTH'(IN_XFERS * AXI_LEN / 8);
  localparam logic [XFER_SIZE_WIDTH-1:0] OUT_BYTES = XFER_SIZE_WIDTH'(OUT_XFERS * AXI_LEN / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SEND, S_AWAIT, S_RECV, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    code_nxt;
  logic [IW-1:0] in_idx;
  logic [OW-1:0] out_idx;
  logic          send_beat, recv_beat;
  logic          wd_expired;

  assign send_beat = (state == S_SEND) && s_axis_tready;
  assign recv_beat = (state == S_RECV) && m_axis_tvalid;

`ifdef MSU_AXIS_TIMEOUT_EN
  logic [31:0] wdog;
  logic        wd_active;

  assign wd_active  = (state == S_SEND) || (state == S_AWAIT) || (state == S_RECV);
  assign wd_expired = wd_active && (wdog == 32'(TIMEOUT_CYCLES - 1));

  // Any sign of progress restarts the window.
  always_ff @(posedge clk) begin
    if (reset || !wd_active || (state_nxt != state) || send_beat || recv_beat)
      wdog <= '0;
    else
      wdog <= wdog + 32'd1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      err_code <= 2'd0;
    end else begin
      state    <= state_nxt;
      err_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = err_code;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ARM;
      S_ARM: begin
        if (s_axis_xfer_size_in_bytes != IN_BYTES) begin
          state_nxt = S_ERROR;
          code_nxt  = 2'd1;
        end else begin
          state_nxt = S_SEND;
        end
      end
      S_SEND:  if (send_beat && (in_idx == IN_LAST)) state_nxt = S_AWAIT;
      S_AWAIT: begin
        if (start_xfer) begin
          if (m_axis_xfer_size_in_bytes != OUT_BYTES) begin
            state_nxt = S_ERROR;
            code_nxt  = 2'd2;
          end else begin
            state_nxt = S_RECV;
          end
        end
      end
      S_RECV:  if (recv_beat && (out_idx == OUT_LAST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_ARM : S_IDLE;
      S_ERROR: if (start) state_nxt = S_ARM;
      default: state_nxt = S_IDLE;
    endcase
    // Expiry loses to a beat or a regular transition in the same cycle.
    if (wd_expired && (state_nxt == state) && !send_beat && !recv_beat) begin
      state_nxt = S_ERROR;
      code_nxt  = 2'd3;
    end
    if (state_nxt == S_ARM) code_nxt = 2'd0;
  end

  always_comb begin
    ap_start      = (state == S_ARM);
    s_axis_tvalid = (state == S_SEND);
    s_axis_tlast  = (state == S_SEND) && (in_idx == IN_LAST);
    s_axis_tdata  = msu_in[in_idx];
    m_axis_tready = (state == S_RECV);
    valid         = (state == S_DONE);
    error         = (state == S_ERROR);
    busy          = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  end

  // Indices wrap on the last beat so they always address a real element.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_idx    <= '0;
      out_idx   <= '0;
      job_count <= 16'd0;
    end else begin
      if (state_nxt == S_ARM) begin
        in_idx  <= '0;
        out_idx <= '0;
      end else begin
        if (send_beat) in_idx <= (in_idx == IN_LAST) ? '0 : in_idx + 1'b1;
        if (recv_beat) out_idx <= (out_idx == OUT_LAST) ? '0 : out_idx + 1'b1;
      end
      if (state_nxt == S_DONE) job_count <= job_count + 16'd1;
    end
  end

  // Result storage deliberately survives reset.
  always_ff @(posedge clk) begin
    if (recv_beat) msu_out[out_idx] <= m_axis_tdata;
  end

endmodule

// File: tb/tb_msu_axis_harness.sv
// Scoreboard bench for msu_axis_harness: random payloads and stalls, directed size errors, reset and watchdog cases.
module tb_msu_axis_harness;
  localparam int AXI_LEN   = 32;
  localparam int IN_XFERS  = 8;
  localparam int OUT_XFERS = 12;
  localparam int XSW       = 32;
  localparam int TMO       = 16;
  localparam int IN_BYTES  = IN_XFERS * AXI_LEN / 8;
  localparam int OUT_BYTES = OUT_XFERS * AXI_LEN / 8;

  logic clk = 1'b0;
  logic reset, start, start_xfer;
  logic [IN_XFERS-1:0][AXI_LEN-1:0]  msu_in;
  logic [OUT_XFERS-1:0][AXI_LEN-1:0] msu_out;
  logic valid, error, busy, ap_start;
  logic [1:0] err_code;
  logic [15:0] job_count;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [AXI_LEN-1:0] s_axis_tdata, m_axis_tdata;
  logic [XSW-1:0] s_size, m_size;
  logic m_axis_tvalid, m_axis_tready;

  msu_axis_harness #(
    .AXI_LEN(AXI_LEN), .IN_XFERS(IN_XFERS), .OUT_XFERS(OUT_XFERS),
    .XFER_SIZE_WIDTH(XSW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .msu_in(msu_in), .msu_out(msu_out),
    .valid(valid), .error(error), .err_code(err_code), .busy(busy),
    .job_count(job_count), .ap_start(ap_start), .start_xfer(start_xfer),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .s_axis_xfer_size_in_bytes(s_size), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready),
    .m_axis_xfer_size_in_bytes(m_size)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AXI_LEN:0]   send_q[$];
  logic [AXI_LEN-1:0] rx_q[$];
  logic [AXI_LEN-1:0] exp_out_q[$];
  int kind_q[$];
  int lat_q[$];
  bit stall_mode = 0;
  bit no_xfer = 0;
  bit rx_ready_seen = 0;
  bit job_done = 0;
  int sent_cnt = 0;
  int start_cyc = 0;
  int model_jc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Core-side model: consumes send beats, produces result beats, raises start_xfer after the last input beat.
  initial begin : msu_side
    bit prev_stall;
    logic [AXI_LEN-1:0] prev_data;
    logic [AXI_LEN:0] e;
    prev_stall = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && s_axis_tvalid) chk("tdata_hold", s_axis_tdata, prev_data);
      s_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axis_tvalid && s_axis_tready) begin
        if (send_q.size() == 0) chk("extra_send_beat", 1, 0);
        else begin
          e = send_q.pop_front();
          chk("s_tdata", s_axis_tdata, e[AXI_LEN-1:0]);
          chk("s_tlast", s_axis_tlast, e[AXI_LEN]);
          if (e[AXI_LEN] && !no_xfer) start_xfer = 1'b1;
        end
        sent_cnt++;
      end
      prev_stall = s_axis_tvalid && !s_axis_tready;
      prev_data = s_axis_tdata;
      if (m_axis_tready) rx_ready_seen = 1;
      if (rx_q.size() != 0) begin
        m_axis_tdata = rx_q[0];
        m_axis_tvalid = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        m_axis_tdata = $urandom;
        m_axis_tvalid = 1'($urandom_range(0, 1));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (rx_q.size() == 0) chk("extra_recv_beat", 1, 0);
        else void'(rx_q.pop_front());
      end
    end
  end

  initial begin : monitor
    bit prev_err;
    int k, l;
    prev_err = 0;
    forever begin
      @(negedge clk);
      #1;
      if (valid) begin
        if (kind_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          k = kind_q.pop_front();
          l = lat_q.pop_front();
          chk("outcome", 0, k);
          if (k == 0) begin
            for (int i = 0; i < OUT_XFERS; i++) chk("msu_out", msu_out[i], exp_out_q.pop_front());
            model_jc++;
          end
          chk("done_err_code", {error, err_code}, 0);
          chk("job_count", job_count, model_jc % 65536);
          if (l >= 0) chk("done_latency", cyc - start_cyc, l);
        end
        job_done = 1;
      end
      if (error && !prev_err) begin
        if (kind_q.size() == 0) chk("unexpected_error", 1, 0);
        else begin
          k = kind_q.pop_front();
          l = lat_q.pop_front();
          chk("err_code", err_code, k);
          if (k == 0) for (int i = 0; i < OUT_XFERS; i++) void'(exp_out_q.pop_front());
          if (l >= 0) chk("err_latency", cyc - start_cyc, l);
        end
        job_done = 1;
      end
      prev_err = error;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
    send_q.delete(); rx_q.delete(); exp_out_q.delete(); kind_q.delete(); lat_q.delete();
    start_xfer = 1'b0;
    model_jc = 0;
  endtask

  // kind: 0 success, 1/2/3 expected err_code, -1 no outcome expected
  task automatic launch(input int in_sz, input int m_sz, input int kind, input int lat,
                        input bit seq_data, input bit nox);
    logic [AXI_LEN-1:0] w;
    for (int i = 0; i < IN_XFERS; i++) begin
      msu_in[i] = seq_data ? AXI_LEN'(i) : AXI_LEN'($urandom);
      if (kind != 1) send_q.push_back({1'(i == IN_XFERS - 1), msu_in[i]});
    end
    if (kind == 0)
      for (int i = 0; i < OUT_XFERS; i++) begin
        w = $urandom;
        rx_q.push_back(w);
        exp_out_q.push_back(w);
      end
    if (kind >= 0) begin
      kind_q.push_back(kind);
      lat_q.push_back(lat);
    end
    s_size = XSW'(in_sz);
    m_size = XSW'(m_sz);
    no_xfer = nox;
    sent_cnt = 0;
    rx_ready_seen = 0;
    job_done = 0;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!job_done && n < 3000) begin
      tick();
      n++;
    end
    if (!job_done) chk("job_wait_expired", 0, 1);
    start_xfer = 1'b0;
  endtask

  task automatic run_job(input int in_sz, input int m_sz, input int kind, input int lat, input bit seq_data);
    launch(in_sz, m_sz, kind, lat, seq_data, 1'b0);
    wait_done();
  endtask

  initial begin : main
    int n;
    reset = 1'b1; start = 1'b0; start_xfer = 1'b0; msu_in = '0;
    s_size = XSW'(IN_BYTES); m_size = XSW'(OUT_BYTES);
    s_axis_tready = 1'b1; m_axis_tvalid = 1'b0; m_axis_tdata = '0;
    tick();
    do_reset();
    chk("reset_flags", {valid, error, err_code, busy, ap_start, s_axis_tvalid, s_axis_tlast, m_axis_tready}, 0);
    chk("reset_job_count", job_count, 0);

    run_job(IN_BYTES, OUT_BYTES, 0, 1 + IN_XFERS + 1 + OUT_XFERS + 1, 1'b1);

    stall_mode = 1;
    for (int j = 0; j < 6; j++) run_job(IN_BYTES, OUT_BYTES, 0, -1, 1'b0);
    stall_mode = 0;

    run_job(28, OUT_BYTES, 1, 2, 1'b0);
    chk("size_err_send_beats", sent_cnt, 0);
    run_job(IN_BYTES, OUT_BYTES, 0, 1 + IN_XFERS + 1 + OUT_XFERS + 1, 1'b0);

    run_job(IN_BYTES, 44, 2, 2 + IN_XFERS + 1, 1'b0);
    chk("m_tready_seen", rx_ready_seen, 0);
    run_job(IN_BYTES, OUT_BYTES, 0, -1, 1'b0);

    launch(IN_BYTES, OUT_BYTES, 0, -1, 1'b0, 1'b0);
    n = 0;
    while (sent_cnt < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_beat3", sent_cnt >= 3, 1);
    do_reset();
    chk("rst_tvalid", s_axis_tvalid, 0);
    chk("rst_flags", {busy, ap_start, m_axis_tready, error, err_code}, 0);
    chk("rst_job_count", job_count, 0);
    run_job(IN_BYTES, OUT_BYTES, 0, 1 + IN_XFERS + 1 + OUT_XFERS + 1, 1'b0);

`ifdef MSU_AXIS_TIMEOUT_EN
    launch(IN_BYTES, OUT_BYTES, 3, 2 + IN_XFERS + TMO, 1'b0, 1'b1);
    wait_done();
    chk("tmo_busy", busy, 0);
`else
    launch(IN_BYTES, OUT_BYTES, -1, -1, 1'b0, 1'b1);
    for (int i = 0; i < 3 * TMO + 20; i++) tick();
    chk("no_tmo_busy", busy, 1);
    chk("no_tmo_error", {error, err_code}, 0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/msu_axis_harness.md
# msu_axis_harness

Parametrised AXI-stream harness that loads one MSU job from a parallel input array, unloads the result into a parallel output array, and reports completion or a coded error. It sits between the simulation/C++ driver and the `msu` core, replacing the fixed 32-bit single-job bench wrapper. It adds the following:
- configurable bus width and beat counts;
- full AXI valid/ready handshaking with `tlast`;
- back-to-back jobs with a job counter;
- registered error reporting;
- an optional watchdog.

## Interface
Parameters:
- AXI_LEN, 32, stream data width in bits; multiple of 8.
- IN_XFERS, 8, beats sent per job (TB->MSU).
- OUT_XFERS, 12, beats received per job (MSU->TB).
- XFER_SIZE_WIDTH, 32, width of xfer-size inputs.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with MSU_AXIS_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin job; sampled only in IDLE, DONE or ERROR.
- msu_in  in  AXI_LEN x IN_XFERS  job payload; must be stable from `start` until `valid`/`error`.
- msu_out  out  AXI_LEN x OUT_XFERS  captured result.
- valid  out  1  one-cycle job-complete pulse.
- error  out  1  level; high in ERROR.
- err_code  out  2  0 none, 1 input-size mismatch, 2 output-size mismatch, 3 timeout.
- busy  out  1  high in any state other than IDLE, DONE or ERROR.
- job_count  out  16  count of successful jobs; wraps.
- ap_start  out  1  one-cycle MSU kick.
- start_xfer  in  1  MSU result ready.
- s_axis_tvalid / s_axis_tlast  out  1  TB->MSU beat valid / last.
- s_axis_tdata  out  AXI_LEN  TB->MSU data.
- s_axis_tready  in  1  MSU accepts.
- s_axis_xfer_size_in_bytes  in  XFER_SIZE_WIDTH  MSU expected input bytes.
- m_axis_tvalid  in  1  MSU->TB beat valid.
- m_axis_tdata  in  AXI_LEN  MSU->TB data.
- m_axis_tready  out  1  harness accepts.
- m_axis_xfer_size_in_bytes  in  XFER_SIZE_WIDTH  MSU output bytes.

## Operation
- States:
  - IDLE: start -> ARM.
  - ARM:
    - If s_axis_xfer_size_in_bytes != IN_XFERS*AXI_LEN/8 -> ERROR (code 1).
    - Otherwise -> SEND.
  - SEND: exits after beat IN_XFERS-1 is accepted -> AWAIT.
  - AWAIT:
    - start_xfer with m size != OUT_XFERS*AXI_LEN/8 -> ERROR (code 2).
    - start_xfer with matching size -> RECV.
  - RECV: exits after beat OUT_XFERS-1 is accepted -> DONE.
  - DONE: start -> ARM; otherwise -> IDLE.
  - ERROR: holds until start (-> ARM, err_code cleared) or reset.
- Outputs per state:
  - ap_start = (state==ARM).
  - s_axis_tvalid = (state==SEND).
  - s_axis_tdata = msu_in[in_idx].
  - s_axis_tlast = SEND and in_idx==IN_XFERS-1.
  - m_axis_tready = (state==RECV).
  - valid = (state==DONE).
- Beat accepted iff tvalid && tready in the same cycle.
  - in_idx increments per accepted send beat.
  - msu_out[out_idx] <= m_axis_tdata and out_idx increments per accepted receive beat.
  - Indices clear on ARM entry.
- m_axis_tvalid outside RECV is ignored; no data captured.
- job_count increments on DONE entry; mod 2^16.
- Reset mid-job:
  - Returns to IDLE next edge; tvalid/tready/ap_start drop immediately after that edge.
  - Indices, job_count, error and err_code clear.
  - msu_out retains previous contents (not reset).

## Timing
- Reset values: valid 0, error 0, err_code 0, busy 0, job_count 0, ap_start 0, s_axis_tvalid 0, s_axis_tlast 0, m_axis_tready 0.
- Cycle numbering, with start high at edge N:
  - ARM during N+1.
  - First send beat offered during N+2.
- Throughput: one beat per cycle in each direction under full ready/valid.
- Minimum start->valid latency: 1 + IN_XFERS + 1 + OUT_XFERS + 1 cycles, with start_xfer asserted the cycle AWAIT is entered.
- s_axis_tdata/tlast stay stable while tvalid && !tready.
- msu_out is valid from the valid cycle until the next accepted beat of a later job.

## Configuration
- MSU_AXIS_TIMEOUT_EN defined:
  - A 32-bit watchdog clears on every state change and every accepted beat, and counts in SEND, AWAIT and RECV.
  - Reaching TIMEOUT_CYCLES -> ERROR (code 3) on the next edge.
  - Beat or state change on the expiry cycle takes priority.
- Undefined: no counter; err_code 3 is never produced; the harness may wait indefinitely.

## Test plan
- AXI_LEN=32, IN=8, OUT=12, sizes 32/48 bytes, tready/tvalid always high, msu_in[i]=i -> 8 send beats with tlast on beat 7; valid exactly 23 cycles after start; msu_out matches driven data; job_count=1.
- Random tready/tvalid stalls (~50%) -> s_axis_tdata held during stalls; no beat dropped or duplicated; msu_out exact.
- s_axis_xfer_size_in_bytes=28 -> no send beats; error=1 and err_code=1 two cycles after start; a later start with size 32 completes with err_code cleared.
- m_axis_xfer_size_in_bytes=44 at start_xfer -> error with err_code=2; m_axis_tready never asserted.
- Reset asserted mid-SEND at beat 3 -> IDLE; s_axis_tvalid 0 the next cycle; job_count 0; a fresh job completes.
- MSU_AXIS_TIMEOUT_EN, TIMEOUT_CYCLES=16, start_xfer never asserted -> err_code=3 exactly 16 cycles after AWAIT entry; without the macro, busy stays high.
